// File: rtl/pe_pkg.sv
// Shared types and default sizes for the PE datapath blocks.
package pe_pkg;

  localparam int W_IN    = 8;
  localparam int W_ACC   = 24;
  localparam int MAX_LEN = 1024;

  typedef logic signed [W_IN-1:0]   act_t;
  typedef logic signed [2*W_IN-1:0] prod_t;
  typedef logic signed [W_ACC-1:0]  acc_t;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} pe_state_e;

endpackage

// File: rtl/pe_mult.sv
// Registered signed multiplier stage with enable; en low freezes product and tags.
module pe_mult #(
  parameter int W_IN = pe_pkg::W_IN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     vld,
  input  logic                     last,
  input  logic signed [W_IN-1:0]   a,
  input  logic signed [W_IN-1:0]   b,
  output logic signed [2*W_IN-1:0] p,
  output logic                     p_valid,
  output logic                     p_last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p       <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (en) begin
      p_valid <= vld;
      if (vld) begin
        p      <= a * b;
        p_last <= last;
      end
    end
  end

endmodule

// File: rtl/pe_mac_acc.sv
// Streaming signed dot-product engine: multiply stage, accumulate stage, held result register.
// Define PE_MAC_SAT_EN for a saturating accumulator; otherwise the sum wraps and out_sat stays 0.
//
// state | meaning
// IDLE  | no partial sum; next product starts a new vector
// ACC   | partial sum held in acc, waiting for more elements
module pe_mac_acc
  import pe_pkg::*;
#(
  parameter int W_IN    = pe_pkg::W_IN,
  parameter int W       = pe_pkg::W_ACC,
  parameter int MAX_LEN = pe_pkg::MAX_LEN,
  localparam int LW     = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [W_IN-1:0] in_act,
  input  logic signed [W_IN-1:0] in_wgt,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [W-1:0]    out_data,
  output logic [LW-1:0]          out_len,
  output logic                   out_sat
);

  localparam int PW = 2 * W_IN;

  logic                 rdy_en, stall, accept, fire;
  logic signed [PW-1:0] p;
  logic                 p_valid, p_last;
  logic signed [W-1:0]  p_ext, acc, base, sum;
  logic [LW-1:0]        cnt, len;
  logic                 clip;
  pe_state_e            state, state_nxt;

  // in_ready must read 0 while rst is high and rise on the first clock after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  assign stall    = out_valid & ~out_ready;
  assign in_ready = rdy_en & ~stall;
  assign accept   = in_valid & in_ready;
  assign fire     = p_valid & ~stall;

  pe_mult #(.W_IN(W_IN)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .en      (~stall),
    .vld     (accept),
    .last    (in_last),
    .a       (in_act),
    .b       (in_wgt),
    .p       (p),
    .p_valid (p_valid),
    .p_last  (p_last)
  );

  assign p_ext = {{(W-PW){p[PW-1]}}, p};
  assign len   = (cnt == LW'(MAX_LEN)) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fire && !p_last) state_nxt = ACC;
      ACC:  if (fire && p_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    base = '0;
    if (state == ACC) base = acc;
  end

`ifdef PE_MAC_SAT_EN
  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic [W:0] sum_w;
  logic       part_sat;

  // Once a partial sum has clipped it stays pinned at that rail until the vector ends
  always_comb begin
    sum_w = {base[W-1], base} + {p_ext[W-1], p_ext};
    sum   = sum_w[W-1:0];
    clip  = 1'b0;
    if (state == ACC && part_sat) begin
      sum  = acc;
      clip = 1'b1;
    end else if (sum_w[W] != sum_w[W-1]) begin
      sum  = sum_w[W] ? MINV : MAXV;
      clip = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       part_sat <= 1'b0;
    else if (fire) part_sat <= p_last ? 1'b0 : clip;
  end
`else
  always_comb begin
    sum  = base + p_ext;
    clip = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (fire) begin
      if (p_last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= len;
      end
    end
  end

  // A completing vector reloads the result even in the cycle the old one is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_len   <= '0;
      out_sat   <= 1'b0;
    end else if (fire && p_last) begin
      out_valid <= 1'b1;
      out_data  <= sum;
      out_len   <= len;
      out_sat   <= clip;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_mac_acc.sv
// Scoreboard bench for pe_mac_acc: arithmetic reference model feeds an expected queue, a monitor pops on each transfer.
module tb_pe_mac_acc;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_last;
  logic signed [7:0] in_act, in_wgt;
  logic out_valid, out_ready, out_sat;
  logic signed [23:0] out_data;
  logic [10:0] out_len;

  always #5 clk = ~clk;

  pe_mac_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_wgt    (in_wgt),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_sat   (out_sat)
  );

  typedef struct {
    longint data;
    int     len;
    bit     sat;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  longint m_sum;
  int     m_n;
  bit     m_sat;
  bit     rnd_rdy = 1'b0;
  int     stall_cnt = 0;
  int     last_acc_cyc = 0;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void model_clear();
    m_sum = 0;
    m_n   = 0;
    m_sat = 1'b0;
  endfunction

  // Reference: plain integer dot product with per-step wrap or sticky clamp
  function automatic void model_pair(int a, int b, bit last);
    longint p;
    exp_t e;
    p = a * b;
    m_n++;
`ifdef PE_MAC_SAT_EN
    if (!m_sat) begin
      m_sum = m_sum + p;
      if (m_sum > 8388607) begin
        m_sum = 8388607;
        m_sat = 1'b1;
      end else if (m_sum < -8388608) begin
        m_sum = -8388608;
        m_sat = 1'b1;
      end
    end
`else
    m_sum = m_sum + p;
    m_sum = ((m_sum % 16777216) + 16777216) % 16777216;
    if (m_sum >= 8388608) m_sum = m_sum - 16777216;
`endif
    if (last) begin
      e.data = m_sum;
      e.len  = (m_n > 1024) ? 1024 : m_n;
      e.sat  = m_sat;
      q.push_back(e);
      model_clear();
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    bit rst_q = 1'b1;
    bit held = 1'b0;
    logic signed [23:0] h_data;
    logic [10:0] h_len;
    logic h_sat;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (!rst_q) begin
          checks++;
          if (in_ready !== !(out_valid && !out_ready)) begin
            errors++;
            $display("FAIL in_ready_rule: got %0b with out_valid=%0b out_ready=%0b", in_ready, out_valid, out_ready);
          end
        end
        if (!in_ready) stall_cnt++;
        if (held) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== h_data || out_len !== h_len || out_sat !== h_sat) begin
            errors++;
            $display("FAIL hold_stable: got v=%0b d=%0d l=%0d s=%0b expected v=1 d=%0d l=%0d s=%0b",
                     out_valid, out_data, out_len, out_sat, h_data, h_len, h_sat);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got d=%0d l=%0d expected no output", out_data, out_len);
          end else begin
            e = q.pop_front();
            if (longint'(out_data) != e.data || int'(out_len) != e.len || out_sat !== e.sat) begin
              errors++;
              $display("FAIL result: got d=%0d l=%0d s=%0b expected d=%0d l=%0d s=%0b",
                       out_data, out_len, out_sat, e.data, e.len, e.sat);
            end
          end
        end
        held   = out_valid && !out_ready;
        h_data = out_data;
        h_len  = out_len;
        h_sat  = out_sat;
      end
      rst_q = rst;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic send(input int a, input int b, input bit last);
    int guard = 0;
    bit done = 1'b0;
    in_act   = a[7:0];
    in_wgt   = b[7:0];
    in_last  = last;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        model_pair(a, b, last);
        if (last) last_acc_cyc = cyc;
      end
      tick();
      guard++;
      if (!done && guard > 200) begin
        errors++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", guard);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((q.size() != 0 || out_valid) && guard < 3000) begin
      tick();
      guard++;
    end
    if (guard >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
    end
  endtask

  initial begin : stim
    bit got;
    int s0;
    int a, b, n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_act = '0;
    in_wgt = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    model_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_len", out_len, 0);
    chk("rst_out_sat", out_sat, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    tick();

    // 1) 4 x (3*4), latency and value
    for (int i = 0; i < 4; i++) send(3, 4, i == 3);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    chk("t1_latency", got ? cyc - last_acc_cyc : -1, 2);
    chk("t1_data", out_data, 48);
    chk("t1_len", out_len, 4);
    tick();
    drain();

    // 2) single element vector
    send(-5, 7, 1'b1);
    drain();

    // 3) 1024 x (-128*-128)
    for (int i = 0; i < 1024; i++) send(-128, -128, i == 1023);
    drain();

    // 4) back-to-back vectors with a held result
    s0 = stall_cnt;
    out_ready = 1'b0;
    fork
      begin
        send(2, 2, 1'b1);
        send(1, 1, 1'b0);
        send(1, 1, 1'b1);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("t4_stall_cycles", (stall_cnt - s0) >= 3, 1);

    // 5) reset mid-vector discards the partial sum
    send(10, 10, 1'b0);
    send(10, 10, 1'b0);
    rst = 1'b1;
    model_clear();
    tick();
    tick();
    chk("t5_rst_out_valid", out_valid, 0);
    rst = 1'b0;
    tick();
    tick();
    send(1, 1, 1'b1);
    drain();

    // 6) mixed signs
    send(127, -128, 1'b0);
    send(-1, -1, 1'b0);
    send(0, 55, 1'b1);
    drain();

    // random vectors with random backpressure and input gaps
    rnd_rdy = 1'b1;
    for (int v = 0; v < 40; v++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        case ($urandom_range(0, 5))
          0: a = -128;
          1: a = 127;
          default: a = $urandom_range(0, 255) - 128;
        endcase
        b = $urandom_range(0, 255) - 128;
        send(a, b, i == n - 1);
      end
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    drain();
    tick();
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish by time limit expected completion");
    $fatal(1, "watchdog");
  end

endmodule
